// File: rtl/sdi_depacketizer.sv
`default_nettype none
// ============================================================================
//  Module   : sdi_depacketizer
//  Purpose  : Receive side of the ST2110 packetizer. Each 32-bit RTP payload
//             word carries {6-bit header, video sample, audio sample}. The
//             header is checked and a HUNT/LOCKED state machine acquires lock.
//             While locked, good words are split into video/audio samples and
//             queued in a small FIFO. The FIFO feeds a valid/ready output
//             toward the IP-to-SDI reconstruction path.
//  Ports    : clk, rst          - single clock, synchronous active-high reset
//             rtp_data[31:0]    - payload word (header | video | audio)
//             rtp_valid         - word valid; always consumed, no backpressure
//             video_data        - video sample at the FIFO head
//             audio_data        - audio sample at the FIFO head
//             out_valid         - FIFO non-empty, head sample presented
//             out_ready         - downstream takes the head on valid && ready
//             locked            - 1 while in LOCKED
//             hdr_err_cnt[15:0] - header-mismatch words, saturating
//             ovf_cnt[15:0]     - words dropped on FIFO full, saturating
//             overflow          - sticky drop flag, cleared only by rst
//  Revision : 1.0 - initial release
// ============================================================================
module sdi_depacketizer #(
  parameter int         VIDEO_WIDTH = 10,
  parameter int         AUDIO_WIDTH = 16,
  parameter logic [5:0] HDR_PATTERN = 6'b100000,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         LOCK_COUNT  = 3,
  parameter int         LOSS_COUNT  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            rtp_data,
  input  logic                   rtp_valid,
  output logic [VIDEO_WIDTH-1:0] video_data,
  output logic [AUDIO_WIDTH-1:0] audio_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   locked,
  output logic [15:0]            hdr_err_cnt,
  output logic [15:0]            ovf_cnt,
  output logic                   overflow
);

  localparam int SAMPLE_W = VIDEO_WIDTH + AUDIO_WIDTH;
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int GOOD_W   = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W    = $clog2(LOSS_COUNT + 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Header check
  // --------------------------------------------------------------------------
  logic                good;
  logic                bad;
  logic [SAMPLE_W-1:0] in_sample;

  assign good      = rtp_valid && (rtp_data[31:26] == HDR_PATTERN);
  assign bad       = rtp_valid && !good;
  assign in_sample = rtp_data[SAMPLE_W-1:0];

  // --------------------------------------------------------------------------
  // Lock state machine
  // --------------------------------------------------------------------------
  state_t            state;
  logic [GOOD_W-1:0] good_run;
  logic [BAD_W-1:0]  bad_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      locked      <= 1'b0;
      good_run    <= '0;
      bad_run     <= '0;
      hdr_err_cnt <= '0;
    end else begin
      if (bad && (hdr_err_cnt != 16'hFFFF))
        hdr_err_cnt <= hdr_err_cnt + 16'd1;

      case (state)
        HUNT: begin
          if (good) begin
            // The word that completes the run is consumed by the lock
            // decision itself and never reaches the FIFO.
            if (good_run == GOOD_W'(LOCK_COUNT - 1)) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              good_run <= '0;
              bad_run  <= '0;
            end else begin
              good_run <= good_run + GOOD_W'(1);
            end
          end else if (bad) begin
            good_run <= '0;
          end
        end
        LOCKED: begin
          if (good) begin
            bad_run <= '0;
          end else if (bad) begin
            if (bad_run == BAD_W'(LOSS_COUNT - 1)) begin
              state    <= HUNT;
              locked   <= 1'b0;
              good_run <= '0;
              bad_run  <= '0;
            end else begin
              bad_run <= bad_run + BAD_W'(1);
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    rd_next;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_after_pop;
  logic [CNT_W-1:0]    count_next;
  logic [SAMPLE_W-1:0] head_sample;
  logic                push_req;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;

  assign push_req = (state == LOCKED) && good;
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign pop      = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    count_after_pop = count - CNT_W'(pop);
    count_next      = count_after_pop + CNT_W'(push);
    rd_next         = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_sample;
  end

  // The head sample is held in its own register so the outputs keep their
  // last value once the FIFO runs empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      head_sample <= '0;
      ovf_cnt     <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_next;
      count     <= count_next;
      out_valid <= (count_next != '0);

      // Next head comes from storage if anything remains after the pop,
      // otherwise straight from the incoming word when one is being pushed.
      if (count_after_pop != '0)
        head_sample <= mem[rd_next];
      else if (push)
        head_sample <= in_sample;

      if (drop) begin
        overflow <= 1'b1;
        if (ovf_cnt != 16'hFFFF)
          ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end

  assign video_data = head_sample[SAMPLE_W-1:AUDIO_WIDTH];
  assign audio_data = head_sample[AUDIO_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_sdi_depacketizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdi_depacketizer
//  Purpose  : Directed self-checking bench for sdi_depacketizer: reset state,
//             lock acquisition, header errors and lock loss, idle gaps,
//             FIFO overflow, full push+pop, and reset in mid-stream.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdi_depacketizer;

  logic        clk;
  logic        rst;
  logic [31:0] rtp_data;
  logic        rtp_valid;
  logic [9:0]  video_data;
  logic [15:0] audio_data;
  logic        out_valid;
  logic        out_ready;
  logic        locked;
  logic [15:0] hdr_err_cnt;
  logic [15:0] ovf_cnt;
  logic        overflow;

  int compared   = 0;
  int mismatched = 0;

  sdi_depacketizer #(
    .VIDEO_WIDTH (10),
    .AUDIO_WIDTH (16),
    .HDR_PATTERN (6'b100000),
    .FIFO_DEPTH  (4),
    .LOCK_COUNT  (3),
    .LOSS_COUNT  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rtp_data    (rtp_data),
    .rtp_valid   (rtp_valid),
    .video_data  (video_data),
    .audio_data  (audio_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .locked      (locked),
    .hdr_err_cnt (hdr_err_cnt),
    .ovf_cnt     (ovf_cnt),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] gw(input logic [9:0] v, input logic [15:0] a);
    return {6'b100000, v, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    rtp_valid = 1'b1;
    rtp_data  = w;
    tick();
    rtp_valid = 1'b0;
    rtp_data  = 32'h0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [9:0]  drain_v [3];
  logic [15:0] drain_a [3];

  initial begin
    rst       = 1'b1;
    rtp_valid = 1'b0;
    rtp_data  = 32'h0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_locked",    locked, 0);
    chk("rst_hdr_err",   hdr_err_cnt, 0);
    chk("rst_ovf_cnt",   ovf_cnt, 0);
    chk("rst_overflow",  overflow, 0);
    chk("rst_video",     video_data, 0);
    chk("rst_audio",     audio_data, 0);
    rst = 1'b0;

    // T1: lock on three good words, fourth is the first forwarded
    send(gw(10'h001, 16'h0001));
    send(gw(10'h002, 16'h0002));
    chk("t1_not_locked_2", locked, 0);
    send(gw(10'h003, 16'h0003));
    chk("t1_locked",       locked, 1);
    chk("t1_third_discard", out_valid, 0);
    send(32'h8155_1234);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_video",     video_data, 10'h155);
    chk("t1_audio",     audio_data, 16'h1234);
    out_ready = 1'b1;
    tick();
    chk("t1_empty",      out_valid, 0);
    chk("t1_hold_video", video_data, 10'h155);
    chk("t1_hold_audio", audio_data, 16'h1234);

    // T2: single bad word keeps lock, two in a row lose it
    send(32'h0000_0000);
    chk("t2_hdr1",    hdr_err_cnt, 1);
    chk("t2_locked1", locked, 1);
    chk("t2_dropped", out_valid, 0);
    send(gw(10'h2AA, 16'hBEEF));
    chk("t2_good_valid", out_valid, 1);
    chk("t2_good_video", video_data, 10'h2AA);
    chk("t2_good_audio", audio_data, 16'hBEEF);
    send(32'h0000_0000);
    chk("t2_hdr2",    hdr_err_cnt, 2);
    chk("t2_locked2", locked, 1);
    chk("t2_popped",  out_valid, 0);
    send(32'h0000_0000);
    chk("t2_hdr3",    hdr_err_cnt, 3);
    chk("t2_unlock",  locked, 0);

    // T6: idle cycles between good words do not break the run
    send(gw(10'h010, 16'h0010));
    tick();
    tick();
    send(gw(10'h011, 16'h0011));
    tick();
    chk("t6_not_locked", locked, 0);
    send(gw(10'h012, 16'h0012));
    chk("t6_locked",    locked, 1);
    chk("t6_no_output", out_valid, 0);

    // T3: six words into a four-deep FIFO with no drain
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(gw(10'(10'h100 + i), 16'(16'hA000 + i)));
      if (i == 3) begin
        chk("t3_full_no_ovf", ovf_cnt, 0);
        chk("t3_full_nosticky", overflow, 0);
      end
    end
    chk("t3_ovf_cnt",  ovf_cnt, 2);
    chk("t3_overflow", overflow, 1);
    chk("t3_head_video", video_data, 10'h100);
    chk("t3_head_audio", audio_data, 16'hA000);

    // T4: full FIFO, push and pop in the same cycle
    out_ready = 1'b1;
    send(gw(10'h1F0, 16'hC0DE));
    chk("t4_ovf_same",  ovf_cnt, 2);
    chk("t4_head_video", video_data, 10'h101);
    chk("t4_head_audio", audio_data, 16'hA001);
    drain_v[0] = 10'h102; drain_a[0] = 16'hA002;
    drain_v[1] = 10'h103; drain_a[1] = 16'hA003;
    drain_v[2] = 10'h1F0; drain_a[2] = 16'hC0DE;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_drain_valid", out_valid, 1);
      chk("t4_drain_video", video_data, drain_v[k]);
      chk("t4_drain_audio", audio_data, drain_a[k]);
    end
    tick();
    chk("t4_drained",    out_valid, 0);
    chk("t4_hold_audio", audio_data, 16'hC0DE);
    chk("t4_sticky",     overflow, 1);

    // T5: reset with entries queued
    out_ready = 1'b0;
    send(gw(10'h201, 16'h0201));
    send(gw(10'h202, 16'h0202));
    send(gw(10'h203, 16'h0203));
    chk("t5_queued", out_valid, 1);
    chk("t5_queued_video", video_data, 10'h201);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_locked",    locked, 0);
    chk("t5_hdr_err",   hdr_err_cnt, 0);
    chk("t5_ovf_cnt",   ovf_cnt, 0);
    chk("t5_overflow",  overflow, 0);
    chk("t5_video",     video_data, 0);
    send(gw(10'h301, 16'h0301));
    send(gw(10'h302, 16'h0302));
    chk("t5_relock_pending", locked, 0);
    send(gw(10'h303, 16'h0303));
    chk("t5_relocked",  locked, 1);
    chk("t5_still_empty", out_valid, 0);
    send(gw(10'h3FF, 16'h5555));
    chk("t5_fwd_valid", out_valid, 1);
    chk("t5_fwd_video", video_data, 10'h3FF);
    chk("t5_fwd_audio", audio_data, 16'h5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
